// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg
//   Shared definitions for the immediate encoder: instruction format
//   encodings (taken from opcode[10:9]), immediate field widths and LSB
//   positions inside the 32-bit word, the control state type, the word
//   packing function and the matching sign-extension (decode) helper.
package imm_encoder_pkg;

    typedef enum logic [1:0] {
        FMT_B   = 2'b00,
        FMT_ILL = 2'b01,
        FMT_CB  = 2'b10,
        FMT_D   = 2'b11
    } fmt_e;

    // Immediate field width / LSB position inside the encoded word.
    localparam int unsigned IMM_W_B    = 26;
    localparam int unsigned IMM_LSB_B  = 0;
    localparam int unsigned IMM_W_CB   = 19;
    localparam int unsigned IMM_LSB_CB = 5;
    localparam int unsigned IMM_W_D    = 9;
    localparam int unsigned IMM_LSB_D  = 12;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Packs a field set into a 32-bit word. Only meaningful for a legal
    // format; the illegal format returns zero.
    function automatic logic [31:0] encode(
        input logic [10:0] opcode,
        input logic [63:0] imm,
        input logic [4:0]  rn,
        input logic [4:0]  rt
    );
        logic [31:0] word;
        word = '0;
        case (fmt_e'(opcode[10:9]))
            FMT_B:   word = {opcode[10:5], imm[IMM_W_B-1:0]};
            FMT_CB:  word = {opcode[10:3], imm[IMM_W_CB-1:0], rt};
            FMT_D:   word = {opcode[10:0], imm[IMM_W_D-1:0], 2'b00, rn, rt};
            default: word = '0;
        endcase
        return word;
    endfunction

    // Recovers the sign-extended immediate from an encoded word.
    function automatic logic [63:0] sext_imm(
        input fmt_e        fmt,
        input logic [31:0] instr
    );
        logic [63:0] value;
        value = '0;
        case (fmt)
            FMT_B:   value = {{(64-IMM_W_B){instr[IMM_LSB_B+IMM_W_B-1]}},
                              instr[IMM_LSB_B +: IMM_W_B]};
            FMT_CB:  value = {{(64-IMM_W_CB){instr[IMM_LSB_CB+IMM_W_CB-1]}},
                              instr[IMM_LSB_CB +: IMM_W_CB]};
            FMT_D:   value = {{(64-IMM_W_D){instr[IMM_LSB_D+IMM_W_D-1]}},
                              instr[IMM_LSB_D +: IMM_W_D]};
            default: value = '0;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// imm_range_check
//   Combinational legality check of a field set.
//   fmt   : instruction format (opcode[10:9])
//   imm   : 64-bit sign-extended immediate
//   legal : 1 when fmt is B/CB/D and imm fits the format's signed field,
//           i.e. imm[63:W-1] are all equal
module imm_range_check
    import imm_encoder_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [63:0] imm,
    output logic        legal
);

    logic fits_b;
    logic fits_cb;
    logic fits_d;

    // A value fits W signed bits when everything from bit W-1 upward is a
    // copy of the sign bit.
    assign fits_b  = (&imm[63:IMM_W_B-1])  | ~(|imm[63:IMM_W_B-1]);
    assign fits_cb = (&imm[63:IMM_W_CB-1]) | ~(|imm[63:IMM_W_CB-1]);
    assign fits_d  = (&imm[63:IMM_W_D-1])  | ~(|imm[63:IMM_W_D-1]);

    always_comb begin
        legal = 1'b0;
        case (fmt_e'(fmt))
            FMT_B:   legal = fits_b;
            FMT_CB:  legal = fits_cb;
            FMT_D:   legal = fits_d;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder
//   Packs opcode/immediate/register field sets into 32-bit B, CB and D
//   format instruction words with a ready/valid handshake on both sides
//   and a single output register (full throughput, one-cycle latency).
//   Each legal word is tagged with a byte address that advances by 4.
//   Rejected sets (illegal format or immediate out of range) are consumed,
//   pulse err, bump a saturating err_cnt and, with STOP_ON_ERR, halt the
//   block until clr.
//
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  / in_ready  : input handshake for opcode, imm, rn, rt
//   out_valid / out_ready : output handshake for instr, out_addr
//   err       : one-cycle pulse after a rejected set is accepted
//   err_cnt   : saturating count of rejected sets
//   halted    : high while in HALT
//   clr       : leave HALT and zero err_cnt
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter bit          STOP_ON_ERR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10:0]       opcode,
    input  logic [63:0]       imm,
    input  logic [4:0]        rn,
    input  logic [4:0]        rt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic              halted,
    input  logic              clr
);

    state_e            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic              legal;
    logic              accept;
    logic              accept_ok;
    logic              accept_bad;

    imm_range_check u_range_check (
        .fmt   (opcode[10:9]),
        .imm   (imm),
        .legal (legal)
    );

    // rst_n gates in_ready so nothing is taken while reset is held.
    assign in_ready   = rst_n && (state == ST_RUN) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign accept_ok  = accept && legal;
    assign accept_bad = accept && !legal;
    assign halted     = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
            instr     <= '0;
            out_addr  <= '0;
            addr_cnt  <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err <= accept_bad;

            // A new legal word overwrites the register in the same edge the
            // old one is taken. A rejected set produces no word, so a word
            // being delivered alongside it simply drains.
            if (accept_ok) begin
                out_valid <= 1'b1;
                instr     <= encode(opcode, imm, rn, rt);
                out_addr  <= addr_cnt;
                addr_cnt  <= addr_cnt + ADDR_W'(4);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (clr) begin
                err_cnt <= '0;
            end else if (accept_bad && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            case (state)
                ST_RUN: begin
                    if (accept_bad && STOP_ON_ERR) begin
                        state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (clr) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter ADDR_W, default 8: width of the instruction-word address counter (byte address).
REQ-002 Parameter STOP_ON_ERR, default 1: when 1, an encoding error halts the block until clr.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1: a field set is presented.
REQ-006 Port in_ready, output, 1: the block accepts the field set this cycle.
REQ-007 Port opcode, input, 11: opcode, left-aligned.
- B format uses opcode[10:5].
- CB format uses opcode[10:3].
- D format uses opcode[10:0].
REQ-008 Port imm, input, 64: sign-extended immediate to be packed.
REQ-009 Port rn, input, 5: base register (D format only).
REQ-010 Port rt, input, 5: target register (CB and D formats).
REQ-011 Port out_valid, output, 1: instr and out_addr hold a valid word.
REQ-012 Port out_ready, input, 1: the downstream consumer takes the word.
REQ-013 Port instr, output, 32: encoded instruction.
REQ-014 Port out_addr, output, ADDR_W: byte address of instr.
REQ-015 Port err, output, 1: one-cycle pulse when an accepted field set is rejected.
REQ-016 Port err_cnt, output, 8: saturating count of rejected field sets.
REQ-017 Port halted, output, 1: high while in HALT.
REQ-018 Port clr, input, 1: synchronous exit from HALT and clear of err_cnt.

Function
REQ-019 Format SHALL be fmt = opcode[10:9]: 00 = B, 10 = CB, 11 = D, 01 = illegal.
REQ-020 B format: instr = {opcode[10:5], imm[25:0]}.
REQ-021 CB format: instr = {opcode[10:3], imm[18:0], rt}.
REQ-022 D format: instr = {opcode[10:0], imm[8:0], 2'b00, rn, rt}.
REQ-023 Range check: the field set is legal only if imm[63:W-1] are all equal.
- W = 26 for B, 19 for CB, 9 for D.
- A legal set decodes back to imm when sign-extended from instr[W-1+lsb:lsb].
REQ-024 An illegal fmt or a failed range check SHALL be an error.
- The set is still consumed (in_ready high).
- No word is produced.
- err pulses the cycle after acceptance.
REQ-025 States: RUN and HALT; reset enters RUN.
REQ-026 RUN -> HALT on the cycle an error is registered, only when STOP_ON_ERR = 1.
REQ-027 HALT -> RUN on clr = 1.
REQ-028 In HALT: in_ready = 0; any pending out_valid word remains deliverable.
REQ-029 In RUN: in_ready = !out_valid || out_ready (single output register, full throughput).
REQ-030 Latency: a legal set accepted in cycle N presents on instr/out_addr with out_valid = 1 in cycle N+1.
REQ-031 instr, out_addr and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-032 Address counter: starts at 0 and increments by 4 per legal accepted word; wraps modulo 2^ADDR_W.
- The first word is emitted with out_addr = 0.
REQ-033 Errors SHALL NOT advance the address counter.
REQ-034 err_cnt saturates at 255.
- clr sets err_cnt to 0 in any state.
- clr has priority over a simultaneous increment.
REQ-035 Simultaneous word delivery (out_valid && out_ready) and new accept: the new word replaces the old in the same edge, with no bubble.
REQ-036 An error accepted while an older word is being delivered: out_valid drops to 0 on the next cycle.

Reset
REQ-037 On rst_n low, asynchronously:
- out_valid = 0, instr = 0, out_addr = 0, address counter = 0;
- err = 0, err_cnt = 0, halted = 0, state = RUN.
REQ-038 Reset mid-handshake SHALL discard the held word without delivering it.
REQ-039 in_ready = 0 while rst_n is low.

Structure
REQ-040 A shared package SHALL hold the format encodings (B = 2'b00, CB = 2'b10, D = 2'b11) and the immediate widths and LSB positions (26/0, 19/5, 9/12).
- The sign-extension block imports the same package.
REQ-041 One combinational sub-module, imm_range_check, SHALL take fmt and imm and return legal.
- The handshake, state machine and counters live in imm_encoder.

Verification
REQ-042 B, imm = -1 (all ones), opcode[10:5] = 000101 -> instr = 0x17FFFFFF, out_addr = 0, err = 0.
REQ-043 D, opcode = 11111000010, imm = 0x100 (256, out of range for 9 bits) -> err pulse, err_cnt = 1, halted = 1, in_ready = 0 until clr.
REQ-044 CB, opcode[10:3] = 10110100, imm = 0x3FFFF, rt = 3 -> instr = 0xB47FFFE3.
- Round-trip: sign-extending instr[23:5] SHALL give 0x000000000003FFFF.
REQ-045 ADDR_W = 4, five legal back-to-back words with out_ready = 1 -> out_addr = 0, 4, 8, 12, 0 on consecutive cycles, no bubbles.
REQ-046 Hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and instr stable for all 3 cycles; accept resumes the cycle out_ready rises.
REQ-047 Assert rst_n low while out_valid = 1 and out_ready = 0 -> out_valid = 0 immediately; the next word emitted after reset has out_addr = 0.
